// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the TX (and later RX) path.
package uart_pkg;

   // Transmit frame sequencer states
   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Idle line is mark (high); a start bit is space (low)
   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings an asynchronous level (baud square wave) into the clk domain and
// produces a one-clk pulse per rising edge. Shared with the RX side.
module tick_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic s1;
   logic s2;
   logic s3;

   // Two synchronizer flops followed by a history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one word per valid/ready handshake and
// shifts it out LSB first as start + data + optional parity + stop bits,
// with every bit boundary aligned to a rising edge of baud_tick.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 busy
);

   localparam int unsigned   CW         = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_BITS - 1);
   localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);
   localparam logic          ODD        = 1'(PARITY_ODD);
   localparam bit            HAS_PARITY = (PARITY_EN != 0);

   tx_state_t            state;
   logic [DATA_BITS-1:0] sr;
   logic [CW-1:0]        bitcnt;
   logic                 stopcnt;
   logic                 parity_bit;
   logic                 bedge;

   tick_edge_sync u_tick_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (baud_tick),
      .rise_pulse (bedge)
   );

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Frame sequencer: handshake in IDLE, every other transition waits for a baud edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         txd        <= LINE_IDLE;
         sr         <= '0;
         bitcnt     <= '0;
         stopcnt    <= 1'b0;
         parity_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               txd <= LINE_IDLE;
               if (tx_valid) begin
                  // Parity of the incoming word equals parity of the latched word
                  sr         <= tx_data;
                  parity_bit <= (^tx_data) ^ ODD;
                  state      <= ARM;
               end
            end
            ARM: begin
               if (bedge) begin
                  txd   <= LINE_START;
                  state <= START;
               end
            end
            START: begin
               if (bedge) begin
                  txd    <= sr[0];
                  sr     <= sr >> 1;
                  bitcnt <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (bedge) begin
                  if (bitcnt == LAST_BIT) begin
                     stopcnt <= 1'b0;
                     if (HAS_PARITY) begin
                        txd   <= parity_bit;
                        state <= PARITY;
                     end else begin
                        txd   <= LINE_IDLE;
                        state <= STOP;
                     end
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                     txd    <= sr[0];
                     sr     <= sr >> 1;
                  end
               end
            end
            PARITY: begin
               if (bedge) begin
                  txd   <= LINE_IDLE;
                  state <= STOP;
               end
            end
            STOP: begin
               if (bedge) begin
                  if (stopcnt == LAST_STOP) begin
                     state <= IDLE;
                  end else begin
                     stopcnt <= stopcnt + 1'b1;
                  end
               end
            end
            default: begin
               txd   <= LINE_IDLE;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
